config_loader: RTL and testbench

Serial configuration controller for the tile array. Accepts a bitstream one bit per handshake and assembles frames of {tile address, tile config word}. For each complete frame it drives the shared config bus (config_en / config_addr / config_data) for exactly one cycle, so the addressed tile latches its connect-block and output-select settings. After NUM_FRAMES frames it reports done.

---
 rtl/config_loader_if.sv | 24 ++
 rtl/config_loader.sv | 114 +++++++++++
 tb/tb_config_loader.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_loader_if.sv
// Serial bitstream handshake plus shared tile configuration bus.
// The loader side uses the master modport; the bitstream source and
// tile array side use the slave modport.
interface config_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 88
) ();
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic              config_en;
  logic [ADDR_W-1:0] config_addr;
  logic [0:DATA_W-1] config_data;

  modport master (
    input  bit_in, bit_valid,
    output bit_ready, config_en, config_addr, config_data
  );

  modport slave (
    output bit_in, bit_valid,
    input  bit_ready, config_en, config_addr, config_data
  );
endinterface

// File: rtl/config_loader.sv
// Serial configuration loader: assembles {address, config word} frames
// from a one-bit-per-handshake stream and writes each completed frame to
// the tile array with a single-cycle config_en strobe.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SHIFT  | accepting frame bits
// COMMIT | one-cycle write strobe of the completed frame
// DONE   | all frames committed; waiting for a new start
module config_loader #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 88,
  parameter int NUM_FRAMES = 4,
  localparam int FC_W      = $clog2(NUM_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  config_loader_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic [FC_W-1:0]  frame_cnt
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  data_idx;
  logic [ADDR_W-1:0] addr_sr;
  // The final data bit is taken straight from bit_in at commit time,
  // so the assembly register stops one bit short of the full word.
  logic [0:DATA_W-2] data_sr;
  logic              ready;
  logic              accept;
  logic              last_bit;
  logic              restart;

  assign accept   = ready && bus.bit_valid;
  assign last_bit = (bit_cnt == CNT_W'(FRAME_W - 1));
  assign data_idx = bit_cnt - CNT_W'(ADDR_W);
  assign restart  = start && ((state == IDLE) || (state == DONE));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    ready         = 1'b0;
    bus.config_en = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept && last_bit) state_nxt = COMMIT;
      end
      COMMIT: begin
        bus.config_en = 1'b1;
        busy          = 1'b1;
        if (frame_cnt + FC_W'(1) == FC_W'(NUM_FRAMES)) state_nxt = DONE;
        else                                           state_nxt = SHIFT;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
    bus.bit_ready = ready;
  end

  // Frame assembly, output capture on COMMIT entry, and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt         <= '0;
      frame_cnt       <= '0;
      addr_sr         <= '0;
      data_sr         <= '0;
      bus.config_addr <= '0;
      bus.config_data <= '0;
    end else begin
      if (restart) begin
        bit_cnt   <= '0;
        frame_cnt <= '0;
      end
      if (accept) begin
        if (last_bit) begin
          bit_cnt         <= '0;
          bus.config_addr <= addr_sr;
          bus.config_data <= {data_sr, bus.bit_in};
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (bit_cnt < CNT_W'(ADDR_W)) addr_sr <= {addr_sr[ADDR_W-2:0], bus.bit_in};
        else if (!last_bit)           data_sr[data_idx] <= bus.bit_in;
      end
      if (state == COMMIT) frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: random frames and handshake
// stalls, checked against expected commits derived from the frame format.
module tb_config_loader;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 88;
  localparam int NF     = 4;
  localparam int FB     = ADDR_W + DATA_W;
  localparam int FC_W   = $clog2(NF + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic [FC_W-1:0] frame_cnt;
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;

  config_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  config_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_FRAMES(NF)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [0:DATA_W-1] d;
    logic [FC_W-1:0]   fc;
    int                c;
  } commit_t;

  commit_t cq[$];

  // Record every cycle in which the write strobe is seen.
  always @(negedge clk)
    if (bus.config_en === 1'b1)
      cq.push_back(commit_t'({bus.config_addr, bus.config_data, frame_cnt, cyc}));

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame format: address MSB first, then data index 0 first.
  function automatic logic frame_bit(input logic [ADDR_W-1:0] a,
                                     input logic [0:DATA_W-1] d, input int k);
    if (k < ADDR_W) return a[ADDR_W-1-k];
    return d[k-ADDR_W];
  endfunction

  function automatic logic [0:DATA_W-1] rand_data();
    logic [0:DATA_W-1] d;
    for (int j = 0; j < DATA_W; j++) d[j] = 1'($urandom);
    return d;
  endfunction

  function automatic bit pop_one(output commit_t e);
    if (cq.size() == 0) begin
      e = '0;
      return 1'b0;
    end
    e = cq.pop_front();
    return 1'b1;
  endfunction

  // mode 0: valid always, 1: valid toggles every cycle, 2: random stalls.
  // start_at >= 0 pulses start when that bit is first presented.
  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [0:DATA_W-1] d,
                            input int mode, input int nbits, input int start_at,
                            output int last_acc);
    logic v;
    logic tog;
    bit   acc;
    int   tries;
    tog = 1'b1;
    last_acc = -1;
    for (int k = 0; k < nbits; k++) begin
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 400) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = tog;
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        tog = ~tog;
        bus.bit_valid = v;
        bus.bit_in    = v ? frame_bit(a, d, k) : 1'($urandom);
        start         = (k == start_at) && (tries == 0);
        acc = v && (bus.bit_ready === 1'b1);
        step();
        tries++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout bit %0d got no bit_ready want accept", k);
        bus.bit_valid = 1'b0;
        start = 1'b0;
        return;
      end
      last_acc = cyc;
    end
    bus.bit_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    sc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    start = 1'b0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.bit_ready, bus.config_en, busy, done} !== 4'b0 || frame_cnt !== '0 ||
        bus.config_addr !== '0 || bus.config_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b en=%b busy=%b done=%b fc=%0d addr=%0d want all 0",
               bus.bit_ready, bus.config_en, busy, done, frame_cnt, bus.config_addr);
    end
    rst = 1'b0;
    bus.bit_valid = 1'b1;
    step();
    step();
    checks++;
    if (bus.bit_ready !== 1'b0 || busy !== 1'b0 || cq.size() != 0) begin
      errors++;
      $display("FAIL idle_after_reset got rdy=%b busy=%b commits=%0d want 0 0 0",
               bus.bit_ready, busy, cq.size());
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [0:DATA_W-1] d;
    commit_t e;
    int sc, la;
    d = '0;
    d[0] = 1'b1;
    pulse_start(sc);
    checks++;
    if (busy !== 1'b1 || bus.bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL shift_entry got busy=%b rdy=%b want 1 1", busy, bus.bit_ready);
    end
    send_frame(6'd5, d, 0, FB, -1, la);
    step();
    checks++;
    if (cq.size() != 1) begin
      errors++;
      $display("FAIL single_commit_count got %0d want 1", cq.size());
    end
    void'(pop_one(e));
    checks++;
    if (e.a !== 6'd5 || e.d !== d) begin
      errors++;
      $display("FAIL single_commit_payload got addr=%0d data=%h want addr=5 data=%h", e.a, e.d, d);
    end
    checks++;
    if (e.c != sc + FB + 1) begin
      errors++;
      $display("FAIL single_commit_latency got %0d want %0d", e.c - sc, FB + 1);
    end
    checks++;
    if (e.fc !== 0 || frame_cnt !== 1 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_counts got fc_in_commit=%0d fc=%0d done=%b busy=%b want 0 1 0 1",
               e.fc, frame_cnt, done, busy);
    end
  endtask

  task automatic test_toggle_valid();
    logic [0:DATA_W-1] d;
    commit_t e;
    int la;
    d = '0;
    d[0] = 1'b1;
    send_frame(6'd5, d, 1, FB, -1, la);
    step();
    checks++;
    if (cq.size() != 1) begin
      errors++;
      $display("FAIL toggle_commit_count got %0d want 1", cq.size());
    end
    void'(pop_one(e));
    checks++;
    if (e.a !== 6'd5 || e.d !== d) begin
      errors++;
      $display("FAIL toggle_payload got addr=%0d data=%h want addr=5 data=%h", e.a, e.d, d);
    end
    checks++;
    if (e.c != la || frame_cnt !== 2) begin
      errors++;
      $display("FAIL toggle_timing got commit_cyc=%0d fc=%0d want %0d 2", e.c, frame_cnt, la);
    end
  endtask

  task automatic test_start_ignored();
    logic [ADDR_W-1:0] a;
    logic [0:DATA_W-1] d;
    commit_t e;
    int la;
    a = 6'($urandom);
    d = rand_data();
    send_frame(a, d, 2, FB, 40, la);
    step();
    checks++;
    if (cq.size() != 1) begin
      errors++;
      $display("FAIL start_ignored_count got %0d want 1", cq.size());
    end
    void'(pop_one(e));
    checks++;
    if (e.a !== a || e.d !== d || e.fc !== 2 || frame_cnt !== 3) begin
      errors++;
      $display("FAIL start_ignored_frame got addr=%0d fc=%0d data=%h want addr=%0d fc=3 data=%h",
               e.a, frame_cnt, e.d, a, d);
    end
  endtask

  task automatic test_fill_to_done();
    logic [ADDR_W-1:0] a;
    logic [0:DATA_W-1] d;
    commit_t e;
    int la;
    a = 6'($urandom);
    d = rand_data();
    send_frame(a, d, 2, FB, -1, la);
    step();
    void'(pop_one(e));
    checks++;
    if (e.a !== a || e.d !== d || e.fc !== 3) begin
      errors++;
      $display("FAIL last_frame got addr=%0d fc=%0d want addr=%0d fc=3", e.a, e.fc, a);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.bit_ready !== 1'b0 || frame_cnt !== NF) begin
      errors++;
      $display("FAIL done_entry got done=%b busy=%b rdy=%b fc=%0d want 1 0 0 %0d",
               done, busy, bus.bit_ready, frame_cnt, NF);
    end
    bus.bit_valid = 1'b1;
    repeat (6) begin
      bus.bit_in = 1'($urandom);
      step();
    end
    bus.bit_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || frame_cnt !== NF || cq.size() != 0) begin
      errors++;
      $display("FAIL done_sticky got done=%b fc=%0d commits=%0d want 1 %0d 0",
               done, frame_cnt, cq.size(), NF);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs[4];
    logic [0:DATA_W-1] datas[4];
    commit_t e;
    int cyc0, sc, la;
    addrs = '{6'd0, 6'd1, 6'd62, 6'd63};
    for (int i = 0; i < 4; i++) datas[i] = rand_data();
    pulse_start(sc);
    checks++;
    if (done !== 1'b0 || frame_cnt !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear got done=%b fc=%0d busy=%b want 0 0 1", done, frame_cnt, busy);
    end
    send_frame(addrs[0], datas[0], 0, FB, -1, la);
    send_frame(addrs[1], datas[1], 0, FB, -1, la);
    send_frame(addrs[2], datas[2], 2, FB, -1, la);
    send_frame(addrs[3], datas[3], 1, FB, -1, la);
    step();
    checks++;
    if (cq.size() != 4) begin
      errors++;
      $display("FAIL b2b_commit_count got %0d want 4", cq.size());
    end
    cyc0 = 0;
    for (int i = 0; i < 4; i++) begin
      void'(pop_one(e));
      checks++;
      if (e.a !== addrs[i] || e.d !== datas[i] || e.fc !== i) begin
        errors++;
        $display("FAIL b2b_frame%0d got addr=%0d fc=%0d data=%h want addr=%0d fc=%0d data=%h",
                 i, e.a, e.fc, e.d, addrs[i], i, datas[i]);
      end
      if (i == 0) cyc0 = e.c;
      if (i == 1) begin
        checks++;
        if (e.c - cyc0 != FB + 1) begin
          errors++;
          $display("FAIL b2b_period got %0d want %0d", e.c - cyc0, FB + 1);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || frame_cnt !== NF) begin
      errors++;
      $display("FAIL b2b_done got done=%b busy=%b fc=%0d want 1 0 %0d", done, busy, frame_cnt, NF);
    end
  endtask

  task automatic test_restart_from_done();
    logic [ADDR_W-1:0] a[4];
    logic [0:DATA_W-1] d[4];
    commit_t e;
    int sc, la;
    a[0] = 6'd3;
    for (int i = 1; i < 4; i++) a[i] = 6'($urandom);
    for (int i = 0; i < 4; i++) d[i] = rand_data();
    pulse_start(sc);
    checks++;
    if (done !== 1'b0 || frame_cnt !== 0) begin
      errors++;
      $display("FAIL restart_done_clear got done=%b fc=%0d want 0 0", done, frame_cnt);
    end
    send_frame(a[0], d[0], 2, FB, -1, la);
    checks++;
    if (done !== 1'b0 || bus.config_en !== 1'b1 || bus.config_addr !== 6'd3) begin
      errors++;
      $display("FAIL restart_first_commit got done=%b en=%b addr=%0d want 0 1 3",
               done, bus.config_en, bus.config_addr);
    end
    for (int i = 1; i < 4; i++) send_frame(a[i], d[i], 2, FB, -1, la);
    step();
    checks++;
    if (cq.size() != 4) begin
      errors++;
      $display("FAIL restart_commit_count got %0d want 4", cq.size());
    end
    for (int i = 0; i < 4; i++) begin
      void'(pop_one(e));
      checks++;
      if (e.a !== a[i] || e.d !== d[i]) begin
        errors++;
        $display("FAIL restart_frame%0d got addr=%0d data=%h want addr=%0d data=%h",
                 i, e.a, e.d, a[i], d[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || frame_cnt !== NF) begin
      errors++;
      $display("FAIL restart_done got done=%b fc=%0d want 1 %0d", done, frame_cnt, NF);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [ADDR_W-1:0] a;
    logic [0:DATA_W-1] d;
    commit_t e;
    int sc, la;
    a = 6'($urandom);
    d = rand_data();
    pulse_start(sc);
    send_frame(a, d, 2, 50, -1, la);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.bit_ready, bus.config_en, busy, done} !== 4'b0 || frame_cnt !== '0 ||
        bus.config_addr !== '0 || bus.config_data !== '0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b en=%b busy=%b done=%b fc=%0d addr=%0d want all 0",
               bus.bit_ready, bus.config_en, busy, done, frame_cnt, bus.config_addr);
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (cq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_commit got commits=%0d busy=%b want 0 0", cq.size(), busy);
    end
    a = 6'($urandom);
    d = rand_data();
    pulse_start(sc);
    send_frame(a, d, 2, FB, -1, la);
    step();
    checks++;
    if (cq.size() != 1) begin
      errors++;
      $display("FAIL post_reset_count got %0d want 1", cq.size());
    end
    void'(pop_one(e));
    checks++;
    if (e.a !== a || e.d !== d || e.fc !== 0 || frame_cnt !== 1) begin
      errors++;
      $display("FAIL post_reset_frame got addr=%0d fc=%0d data=%h want addr=%0d fc=1 data=%h",
               e.a, frame_cnt, e.d, a, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_toggle_valid();
    test_start_ignored();
    test_fill_to_done();
    test_back_to_back();
    test_restart_from_done();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
